register_file: RTL

- Architectural register file plus rename-tag table for the Tomasulo core.
- Receiving end of the reorder buffer's commit interface (rob_to_rf_*): writes committed values and retires rename tags.
- Records the destination rename (rd -> ROB index) at issue and answers the issue unit's rs1/rs2 lookups with a value, a busy flag and a ROB dependency tag.
- Flushes all renames on ROB misprediction clear.

---
 rtl/register_file.sv | 114 +++++++++++
 1 files changed

// File: rtl/register_file.sv
// Architectural register file with rename-tag table for the Tomasulo core.
// Optional macro RF_COMMIT_BYPASS_EN forwards a same-cycle commit onto the read ports.
module register_file #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 clr_in,

    input  logic                 issue_ready,
    input  logic [4:0]           issue_rd_id,
    input  logic [ROB_WIDTH-1:0] issue_rob_index,

    input  logic [4:0]           rs1_id,
    output logic                 rs1_busy,
    output logic [ROB_WIDTH-1:0] rs1_depend,
    output logic [31:0]          rs1_val,

    input  logic [4:0]           rs2_id,
    output logic                 rs2_busy,
    output logic [ROB_WIDTH-1:0] rs2_depend,
    output logic [31:0]          rs2_val,

    input  logic                 rob_to_rf_ready,
    input  logic [4:0]           rob_to_rf_reg_id,
    input  logic [31:0]          rob_to_rf_reg_val,
    input  logic [ROB_WIDTH-1:0] rob_to_rf_rob_index
);

    logic [31:0]          r_val  [32];
    logic [ROB_WIDTH-1:0] r_tag  [32];
    logic [31:0]          r_busy;

    logic w_commit_en;
    logic w_commit_match;
    logic w_issue_en;

    // The mispredicting branch commits alongside the clear, so a clear also lets a commit through.
    assign w_commit_en    = rob_to_rf_ready && (rdy_in || clr_in) && (rob_to_rf_reg_id != 5'd0);
    assign w_commit_match = r_busy[rob_to_rf_reg_id] &&
                            (r_tag[rob_to_rf_reg_id] == rob_to_rf_rob_index);
    assign w_issue_en     = issue_ready && rdy_in && !clr_in && (issue_rd_id != 5'd0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy <= '0;
            // NOTE: the value array is reset explicitly because x-reads after reset must return 0.
            for (int i = 0; i < 32; i++) begin
                r_val[i] <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            if (w_commit_en) begin
                r_val[rob_to_rf_reg_id] <= rob_to_rf_reg_val;
            end

            if (clr_in) begin
                r_busy <= '0;
                for (int i = 0; i < 32; i++) begin
                    r_tag[i] <= '0;
                end
            end else begin
                if (w_commit_en && w_commit_match) begin
                    r_busy[rob_to_rf_reg_id] <= 1'b0;
                end
                // NOTE: the last non-blocking assignment wins, so issue overrides a same-register commit clear.
                if (w_issue_en) begin
                    r_busy[issue_rd_id] <= 1'b1;
                    r_tag[issue_rd_id]  <= issue_rob_index;
                end
            end
        end
    end

`ifdef RF_COMMIT_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1 = rob_to_rf_ready && rdy_in && (rob_to_rf_reg_id == rs1_id) && (rs1_id != 5'd0);
    assign w_fwd2 = rob_to_rf_ready && rdy_in && (rob_to_rf_reg_id == rs2_id) && (rs2_id != 5'd0);
`endif

    always_comb begin
        rs1_val    = r_val[rs1_id];
        rs1_busy   = r_busy[rs1_id];
        rs1_depend = r_busy[rs1_id] ? r_tag[rs1_id] : '0;
`ifdef RF_COMMIT_BYPASS_EN
        if (w_fwd1) begin
            rs1_val = rob_to_rf_reg_val;
            if (r_busy[rs1_id] && (r_tag[rs1_id] == rob_to_rf_rob_index)) begin
                rs1_busy   = 1'b0;
                rs1_depend = '0;
            end
        end
`endif
    end

    always_comb begin
        rs2_val    = r_val[rs2_id];
        rs2_busy   = r_busy[rs2_id];
        rs2_depend = r_busy[rs2_id] ? r_tag[rs2_id] : '0;
`ifdef RF_COMMIT_BYPASS_EN
        if (w_fwd2) begin
            rs2_val = rob_to_rf_reg_val;
            if (r_busy[rs2_id] && (r_tag[rs2_id] == rob_to_rf_rob_index)) begin
                rs2_busy   = 1'b0;
                rs2_depend = '0;
            end
        end
`endif
    end

endmodule
